// File: rtl/frq_divider_pkg.sv
// Shared definitions for the multi-channel frequency divider:
// default parameters, channel FSM state type and the half-period ROM.
package frq_divider_pkg;

   localparam int DEF_NUM_CH = 2;
   localparam int DEF_SEL_W  = 5;
   localparam int DEF_CNT_W  = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_e;

   // Half-period table. Index 0 means "off"; 1..16 are powers of two,
   // 17..31 are multiples of three; anything beyond 31 is also "off".
   // The largest entry (2^15) fits in 16 bits, the minimum counter width.
   function automatic logic [15:0] rom_half(input int unsigned idx);
      logic [15:0] h;
      if (idx == 0) begin
         h = 16'd0;
      end else if (idx <= 16) begin
         h = 16'(32'd1 << (idx - 1));
      end else if (idx <= 31) begin
         h = 16'(3 * (idx - 16));
      end else begin
         h = 16'd0;
      end
      return h;
   endfunction

endpackage

// File: rtl/frq_divider_pro_if.sv
// Control/status bundle for the divider: per-channel enables and selects
// in, divided clocks, ticks and in-effect selects out.
interface frq_divider_pro_if #(
   parameter int NUM_CH = 2,
   parameter int SEL_W  = 5
);
   logic [NUM_CH-1:0]       en;
   logic [NUM_CH*SEL_W-1:0] f_select;
   logic [NUM_CH-1:0]       clk_out;
   logic [NUM_CH-1:0]       tick;
   logic [NUM_CH*SEL_W-1:0] active_sel;

   modport master (
      output en,
      output f_select,
      input  clk_out,
      input  tick,
      input  active_sel
   );

   modport slave (
      input  en,
      input  f_select,
      output clk_out,
      output tick,
      output active_sel
   );
endinterface

// File: rtl/frq_div_channel.sv
// One divider channel: IDLE/HIGH/LOW FSM with a half-period counter.
// The selector and half-period are only sampled at a period start, so a
// period in flight always completes with the ratio it started with.
module frq_div_channel
   import frq_divider_pkg::*;
#(
   parameter int SEL_W = DEF_SEL_W,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en_i,
   input  logic [SEL_W-1:0] sel_i,
   output logic             clk_out_o,
   output logic             tick_o,
   output logic [SEL_W-1:0] active_sel_o
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] h_act_q, h_act_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             clk_out_q, clk_out_d;
   logic             tick_q, tick_d;

   logic [CNT_W-1:0] rom_half_w;
   logic             start_ok_w;
   logic             last_cnt_w;

   // Per-channel combinational ROM lookup and period-boundary qualifiers.
   always_comb begin
      rom_half_w = CNT_W'(rom_half(32'(sel_i)));
      start_ok_w = en_i && (rom_half_w != '0);
      last_cnt_w = (cnt_q == (h_act_q - CNT_W'(1)));
   end

   // Next-state and next-output logic; only period starts latch a new ratio.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      h_act_d   = h_act_q;
      sel_d     = sel_q;
      clk_out_d = clk_out_q;
      tick_d    = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d     = '0;
            clk_out_d = 1'b0;
            if (start_ok_w) begin
               state_d   = HIGH;
               h_act_d   = rom_half_w;
               sel_d     = sel_i;
               clk_out_d = 1'b1;
               tick_d    = 1'b1;
            end
         end
         HIGH: begin
            if (last_cnt_w) begin
               state_d   = LOW;
               cnt_d     = '0;
               clk_out_d = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         LOW: begin
            if (last_cnt_w) begin
               cnt_d = '0;
               if (start_ok_w) begin
                  state_d   = HIGH;
                  h_act_d   = rom_half_w;
                  sel_d     = sel_i;
                  clk_out_d = 1'b1;
                  tick_d    = 1'b1;
               end else begin
                  state_d   = IDLE;
                  clk_out_d = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d   = IDLE;
            cnt_d     = '0;
            clk_out_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset clears everything immediately.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         h_act_q   <= '0;
         sel_q     <= '0;
         clk_out_q <= 1'b0;
         tick_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         h_act_q   <= h_act_d;
         sel_q     <= sel_d;
         clk_out_q <= clk_out_d;
         tick_q    <= tick_d;
      end
   end

   assign clk_out_o    = clk_out_q;
   assign tick_o       = tick_q;
   assign active_sel_o = sel_q;

endmodule

// File: rtl/frq_divider_pro.sv
// Multi-channel programmable clock divider. Each channel is a fully
// independent frq_div_channel; only the read-only ROM table is common.
module frq_divider_pro
   import frq_divider_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int SEL_W  = DEF_SEL_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input logic              clk,
   input logic              reset_n,
   frq_divider_pro_if.slave bus
);

   if (CNT_W < 16) begin : g_cnt_w_check
      $error("frq_divider_pro: CNT_W must be at least 16");
   end
   if (NUM_CH < 1 || NUM_CH > 8) begin : g_num_ch_check
      $error("frq_divider_pro: NUM_CH must be in 1..8");
   end
   if (SEL_W < 1 || SEL_W > 30) begin : g_sel_w_check
      $error("frq_divider_pro: SEL_W must be in 1..30");
   end

   logic [NUM_CH-1:0]       clk_out_w;
   logic [NUM_CH-1:0]       tick_w;
   logic [NUM_CH*SEL_W-1:0] active_sel_w;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      frq_div_channel #(
         .SEL_W (SEL_W),
         .CNT_W (CNT_W)
      ) u_ch (
         .clk          (clk),
         .reset_n      (reset_n),
         .en_i         (bus.en[gi]),
         .sel_i        (bus.f_select[gi*SEL_W +: SEL_W]),
         .clk_out_o    (clk_out_w[gi]),
         .tick_o       (tick_w[gi]),
         .active_sel_o (active_sel_w[gi*SEL_W +: SEL_W])
      );
   end

   assign bus.clk_out    = clk_out_w;
   assign bus.tick       = tick_w;
   assign bus.active_sel = active_sel_w;

endmodule

// File: tb/tb_frq_divider_pro.sv
// Bench for frq_divider_pro: directed scenarios followed by random
// enable/select/reset traffic, all checked every cycle against a
// period-position reference model.
module tb_frq_divider_pro;

   localparam int NCH = 2;
   localparam int SW  = 5;

   logic clk = 1'b0;
   logic reset_n;
   int   checks   = 0;
   int   failures = 0;

   // Reference model: per channel, whether a period is in flight, the
   // position inside it (0 .. 2h-1), its half-period and the latched select.
   int m_run  [NCH];
   int m_pos  [NCH];
   int m_h    [NCH];
   int m_asel [NCH];

   always #5 clk = ~clk;

   frq_divider_pro_if #(.NUM_CH(NCH), .SEL_W(SW)) bus ();

   frq_divider_pro #(.NUM_CH(NCH), .SEL_W(SW), .CNT_W(16)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   function automatic int ref_half(input int k);
      if (k == 0)       return 0;
      else if (k <= 16) return 2 ** (k - 1);
      else if (k <= 31) return 3 * (k - 16);
      else              return 0;
   endfunction

   task automatic set_sel(input int c, input int s);
      bus.f_select[c*SW +: SW] = SW'(s);
   endtask

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_run[c]  = 0;
         m_pos[c]  = 0;
         m_h[c]    = 0;
         m_asel[c] = 0;
      end
   endtask

   // Advance the model by one rising edge using the inputs seen at that edge.
   task automatic model_edge();
      for (int c = 0; c < NCH; c++) begin
         int s;
         s = int'(bus.f_select[c*SW +: SW]);
         if (m_run[c] == 0 || m_pos[c] == 2 * m_h[c] - 1) begin
            if (bus.en[c] && ref_half(s) != 0) begin
               m_run[c]  = 1;
               m_pos[c]  = 0;
               m_h[c]    = ref_half(s);
               m_asel[c] = s;
            end else begin
               m_run[c] = 0;
               m_pos[c] = 0;
            end
         end else begin
            m_pos[c] = m_pos[c] + 1;
         end
      end
   endtask

   task automatic check_outputs(input string tag);
      for (int c = 0; c < NCH; c++) begin
         logic            exp_clk;
         logic            exp_tick;
         logic [SW-1:0]   exp_sel;
         logic [SW-1:0]   got_sel;
         exp_clk  = (m_run[c] != 0) && (m_pos[c] < m_h[c]);
         exp_tick = (m_run[c] != 0) && (m_pos[c] == 0);
         exp_sel  = SW'(m_asel[c]);
         got_sel  = bus.active_sel[c*SW +: SW];
         checks++;
         assert (bus.clk_out[c] === exp_clk) else begin
            failures++;
            $error("FAIL %s clk_out ch%0d t=%0t got=%b exp=%b", tag, c, $time, bus.clk_out[c], exp_clk);
         end
         checks++;
         assert (bus.tick[c] === exp_tick) else begin
            failures++;
            $error("FAIL %s tick ch%0d t=%0t got=%b exp=%b", tag, c, $time, bus.tick[c], exp_tick);
         end
         checks++;
         assert (got_sel === exp_sel) else begin
            failures++;
            $error("FAIL %s active_sel ch%0d t=%0t got=%0d exp=%0d", tag, c, $time, got_sel, exp_sel);
         end
      end
   endtask

   task automatic cycle(input int n, input string tag);
      repeat (n) begin
         @(posedge clk);
         model_edge();
         #1;
         check_outputs(tag);
      end
   endtask

   // Pulse reset between edges and confirm outputs clear without a clock edge.
   task automatic async_reset_pulse(input string tag);
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      check_outputs(tag);
      #1 reset_n = 1'b1;
   endtask

   initial begin
      int r;
      reset_n      = 1'b0;
      bus.en       = '0;
      bus.f_select = '0;
      model_reset();
      #2;
      check_outputs("reset");
      @(negedge clk);
      reset_n = 1'b1;
      cycle(2, "idle");

      // Divide-by-2 on channel 0.
      set_sel(0, 1);
      bus.en[0] = 1'b1;
      cycle(8, "div2");

      // Select change to H=4, then to H=3 while HIGH of the H=4 period.
      set_sel(0, 3);
      cycle(10, "sel3");
      set_sel(0, 17);
      cycle(20, "sel17");

      // Channel 1 H=6, enable dropped two cycles into HIGH.
      bus.en[0] = 1'b0;
      set_sel(1, 18);
      bus.en[1] = 1'b1;
      cycle(3, "ch1_start");
      bus.en[1] = 1'b0;
      cycle(20, "ch1_drain");

      // Asynchronous reset in the middle of an H=16 HIGH phase.
      set_sel(0, 5);
      bus.en[0] = 1'b1;
      cycle(5, "sel5");
      async_reset_pulse("async_rst");
      cycle(6, "restart");

      // Channel 0 divide-by-4, channel 1 enabled with select 0, then select 1.
      set_sel(0, 2);
      set_sel(1, 0);
      bus.en = 2'b11;
      cycle(12, "ch1_off");
      set_sel(1, 1);
      cycle(12, "ch1_div2");

      // Random enable/select traffic with occasional resets.
      for (int i = 0; i < 1500; i++) begin
         for (int c = 0; c < NCH; c++) begin
            if ($urandom_range(0, 7) == 0)
               bus.en[c] = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) begin
               r = int'($urandom_range(0, 21));
               set_sel(c, (r < 7) ? r : r + 10);
            end
         end
         if ($urandom_range(0, 299) == 0)
            async_reset_pulse("rand_rst");
         cycle(1, "random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
